// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared ALU: one operation in flight,
// registered operands, response hold until consumed. Optional WAIT timeout: ALU_ARB_TIMEOUT_EN.
module alu_arbiter #(
  parameter int WIDTH = 16,
  parameter int FUN_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0_VALID,
  output logic             REQ0_READY,
  input  logic [WIDTH-1:0] REQ0_A,
  input  logic [WIDTH-1:0] REQ0_B,
  input  logic [FUN_W-1:0] REQ0_FUN,
  input  logic             REQ1_VALID,
  output logic             REQ1_READY,
  input  logic [WIDTH-1:0] REQ1_A,
  input  logic [WIDTH-1:0] REQ1_B,
  input  logic [FUN_W-1:0] REQ1_FUN,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic [FUN_W-1:0] ALU_FUN,
  output logic             ALU_EN,
  input  logic [WIDTH-1:0] ALU_OUT,
  input  logic             ALU_OUT_VALID,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic             RSP_ID,
  output logic [WIDTH-1:0] RSP_DATA,
  output logic             RSP_ERR
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_e;
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [FUN_W-1:0] fun;
  } op_t;

  state_e           state_q, state_d;
  op_t              op_q, op_d;
  op_t [1:0]        req_op;
  logic             id_q, id_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       req_vld;
  logic             gnt_vld, gnt_id;
`ifdef ALU_ARB_TIMEOUT_EN
  logic [3:0]       cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  assign req_vld   = {REQ1_VALID, REQ0_VALID};
  assign req_op[0] = {REQ0_A, REQ0_B, REQ0_FUN};
  assign req_op[1] = {REQ1_A, REQ1_B, REQ1_FUN};
  assign gnt_vld   = |req_vld;
  // last_q holds the last served ID; contention goes to the other one
  assign gnt_id    = (&req_vld) ? ~last_q : req_vld[1];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      op_q   <= '0;
      id_q   <= 1'b0;
      last_q <= 1'b1;
      data_q <= '0;
`ifdef ALU_ARB_TIMEOUT_EN
      cnt_q  <= '0;
      err_q  <= 1'b0;
`endif
    end else begin
      op_q   <= op_d;
      id_q   <= id_d;
      last_q <= last_d;
      data_q <= data_d;
`ifdef ALU_ARB_TIMEOUT_EN
      cnt_q  <= cnt_d;
      err_q  <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    id_d    = id_q;
    last_d  = last_q;
    data_d  = data_q;
`ifdef ALU_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: if (gnt_vld) begin
        state_d = ISSUE;
        op_d    = req_op[gnt_id];
        id_d    = gnt_id;
        last_d  = gnt_id;
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef ALU_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        if (ALU_OUT_VALID) begin
          state_d = RESP;
          data_d  = ALU_OUT;
`ifdef ALU_ARB_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (cnt_q == 4'd14) begin
          // this is the 15th silent WAIT cycle
          state_d = RESP;
          data_d  = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + 4'd1;
`endif
        end
      end
      RESP: if (RSP_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    REQ0_READY = 1'b0;
    REQ1_READY = 1'b0;
    ALU_EN     = 1'b0;
    RSP_VALID  = 1'b0;
    case (state_q)
      IDLE: begin
        // gated by RST so READY stays low while reset is held
        REQ0_READY = RST && REQ0_VALID && !gnt_id;
        REQ1_READY = RST && REQ1_VALID && gnt_id;
      end
      ISSUE:   ALU_EN    = 1'b1;
      RESP:    RSP_VALID = 1'b1;
      default: ;
    endcase
  end

  assign ALU_A    = op_q.a;
  assign ALU_B    = op_q.b;
  assign ALU_FUN  = op_q.fun;
  assign RSP_ID   = id_q;
  assign RSP_DATA = data_q;
`ifdef ALU_ARB_TIMEOUT_EN
  assign RSP_ERR  = err_q;
`else
  assign RSP_ERR  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table of full transactions plus hand
// sequences for reset-in-WAIT, stray ALU strobe and WAIT timeout behaviour.
module tb_alu_arbiter;
  localparam int W = 16;
  localparam int F = 4;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         REQ0_VALID = 1'b0, REQ1_VALID = 1'b0;
  logic         REQ0_READY, REQ1_READY;
  logic [W-1:0] REQ0_A = '0, REQ0_B = '0, REQ1_A = '0, REQ1_B = '0;
  logic [F-1:0] REQ0_FUN = '0, REQ1_FUN = '0;
  logic [W-1:0] ALU_A, ALU_B, RSP_DATA;
  logic [F-1:0] ALU_FUN;
  logic         ALU_EN, RSP_VALID, RSP_ID, RSP_ERR;
  logic [W-1:0] ALU_OUT = '0;
  logic         ALU_OUT_VALID = 1'b0;
  logic         RSP_READY = 1'b0;

  alu_arbiter #(.WIDTH(W), .FUN_W(F)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY),
    .REQ0_A(REQ0_A), .REQ0_B(REQ0_B), .REQ0_FUN(REQ0_FUN),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY),
    .REQ1_A(REQ1_A), .REQ1_B(REQ1_B), .REQ1_FUN(REQ1_FUN),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VALID(ALU_OUT_VALID),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID),
    .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic         v0, v1, keep;
    logic [W-1:0] a0, b0;
    logic [F-1:0] f0;
    logic [W-1:0] a1, b1;
    logic [F-1:0] f1;
    logic [W-1:0] res;
    logic         exp_id;
    int           bp;
  } vec_t;

  vec_t tbl[8];
  vec_t v;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [63:0] all_out();
    return {6'b0, REQ0_READY, REQ1_READY, ALU_A, ALU_B, ALU_FUN, ALU_EN,
            RSP_VALID, RSP_ID, RSP_DATA, RSP_ERR};
  endfunction

  // Starts and ends at a falling edge with the DUT in IDLE
  task automatic txn(input vec_t t);
    logic [W-1:0] ea, eb;
    logic [F-1:0] ef;
    ea = t.exp_id ? t.a1 : t.a0;
    eb = t.exp_id ? t.b1 : t.b0;
    ef = t.exp_id ? t.f1 : t.f0;
    REQ0_VALID = t.v0; REQ0_A = t.a0; REQ0_B = t.b0; REQ0_FUN = t.f0;
    REQ1_VALID = t.v1; REQ1_A = t.a1; REQ1_B = t.b1; REQ1_FUN = t.f1;
    #1;
    chk("grant", {REQ1_READY, REQ0_READY}, t.exp_id ? 2'b10 : 2'b01);
    tick();
    if (!t.keep) begin REQ0_VALID = 1'b0; REQ1_VALID = 1'b0; end
    ALU_OUT = t.res;
    @(negedge CLK);
    chk("issue_en_rdy", {ALU_EN, REQ1_READY, REQ0_READY}, 3'b100);
    chk("issue_ops", {ALU_A, ALU_B, ALU_FUN}, {ea, eb, ef});
    tick();
    ALU_OUT_VALID = 1'b1;
    @(negedge CLK);
    chk("wait_quiet", {ALU_EN, RSP_VALID}, 2'b00);
    tick();
    ALU_OUT_VALID = 1'b0;
    ALU_OUT = 16'hDEAD;
    RSP_READY = (t.bp == 0);
    @(negedge CLK);
    chk("rsp", {RSP_VALID, RSP_ID, RSP_DATA, RSP_ERR}, {1'b1, t.exp_id, t.res, 1'b0});
    if (t.bp > 0) begin
      REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
      for (int i = 0; i < t.bp; i++) begin
        tick();
        @(negedge CLK);
        chk("bp_hold", {RSP_VALID, RSP_DATA, REQ1_READY, REQ0_READY, ALU_EN},
            {1'b1, t.res, 3'b000});
      end
      REQ0_VALID = t.keep & t.v0;
      REQ1_VALID = t.keep & t.v1;
      RSP_READY = 1'b1;
    end
    tick();
    RSP_READY = 1'b0;
    @(negedge CLK);
    chk("rsp_done_hold", {RSP_VALID, ALU_A, ALU_B}, {1'b0, ea, eb});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          v0 v1 keep a0        b0        f0    a1        b1        f1    res       id bp
    tbl[0] = '{1, 1, 1, 16'h0011, 16'h0022, 4'h0, 16'h0101, 16'h0202, 4'h4, 16'h0033, 0, 0};
    tbl[1] = '{1, 1, 1, 16'h1000, 16'h0001, 4'h8, 16'h00F0, 16'h0F0F, 4'h5, 16'h0FFF, 1, 0};
    tbl[2] = '{1, 1, 1, 16'h7FFF, 16'h0001, 4'h1, 16'h8000, 16'h0003, 4'hC, 16'h8000, 0, 0};
    tbl[3] = '{1, 1, 0, 16'h0003, 16'h0004, 4'h2, 16'hFFFF, 16'h0001, 4'hD, 16'h7FFF, 1, 0};
    tbl[4] = '{0, 1, 0, 16'h0000, 16'h0000, 4'h0, 16'h1234, 16'h4321, 4'h6, 16'h5555, 1, 0};
    tbl[5] = '{1, 0, 0, 16'h0005, 16'hFFFD, 4'h0, 16'h0000, 16'h0000, 4'h0, 16'h0002, 0, 0};
    tbl[6] = '{1, 0, 0, 16'h0007, 16'h0009, 4'h9, 16'h0000, 16'h0000, 4'h0, 16'h0001, 0, 5};
    tbl[7] = '{1, 1, 0, 16'h0101, 16'h0001, 4'hE, 16'hAAAA, 16'h5555, 4'hA, 16'h00AA, 1, 0};

    // Reset: outputs zero, READY suppressed even with a request present
    repeat (2) @(negedge CLK);
    chk("reset_outputs", all_out(), 64'd0);
    REQ0_VALID = 1'b1;
    #1;
    chk("reset_ready", {REQ1_READY, REQ0_READY}, 2'b00);
    REQ0_VALID = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 8; i++) txn(tbl[i]);

    // Stray ALU strobe in IDLE is ignored
    ALU_OUT = 16'h1234;
    ALU_OUT_VALID = 1'b1;
    tick();
    ALU_OUT_VALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("stray_ignored", {RSP_VALID, ALU_EN, RSP_DATA}, {2'b00, 16'h00AA});
      if (i < 2) tick();
    end

    // Reset while in WAIT drops the transaction
    REQ0_VALID = 1'b1; REQ0_A = 16'h0F0F; REQ0_B = 16'h0001; REQ0_FUN = 4'h3;
    REQ1_VALID = 1'b0;
    #1;
    chk("rw_grant", {REQ1_READY, REQ0_READY}, 2'b01);
    tick();
    REQ0_VALID = 1'b0;
    tick();
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("rw_reset_now", all_out(), 64'd0);
    repeat (2) @(negedge CLK);
    chk("rw_reset_held", all_out(), 64'd0);
    RST = 1'b1;
    ALU_OUT = 16'hBEEF;
    ALU_OUT_VALID = 1'b1;
    tick();
    ALU_OUT_VALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("rw_no_rsp", {RSP_VALID, ALU_EN, RSP_DATA}, 18'd0);
      if (i < 2) tick();
    end
    v = '{0, 1, 0, 16'h0000, 16'h0000, 4'h0, 16'h0042, 16'h0024, 4'h7, 16'h0066, 1, 0};
    txn(v);

`ifdef ALU_ARB_TIMEOUT_EN
    // ALU never answers: error response after 15 WAIT cycles
    REQ0_VALID = 1'b1; REQ0_A = 16'h0001; REQ0_B = 16'h0002; REQ0_FUN = 4'h0;
    tick();
    REQ0_VALID = 1'b0;
    tick();
    for (int k = 1; k <= 14; k++) tick();
    @(negedge CLK);
    chk("tmo_early", RSP_VALID, 1'b0);
    tick();
    @(negedge CLK);
    chk("tmo_rsp", {RSP_VALID, RSP_ERR, RSP_DATA}, {2'b11, 16'h0000});
    RSP_READY = 1'b1;
    tick();
    RSP_READY = 1'b0;
    @(negedge CLK);
    // Result arriving in the 15th WAIT cycle wins over the timeout
    REQ0_VALID = 1'b1;
    tick();
    REQ0_VALID = 1'b0;
    tick();
    for (int k = 1; k <= 14; k++) tick();
    ALU_OUT = 16'h0777;
    ALU_OUT_VALID = 1'b1;
    tick();
    ALU_OUT_VALID = 1'b0;
    @(negedge CLK);
    chk("tmo_race", {RSP_VALID, RSP_ERR, RSP_DATA}, {2'b10, 16'h0777});
    RSP_READY = 1'b1;
    tick();
    RSP_READY = 1'b0;
    @(negedge CLK);
`else
    // Without the timeout, WAIT persists until the ALU answers
    REQ0_VALID = 1'b1; REQ0_A = 16'h0001; REQ0_B = 16'h0002; REQ0_FUN = 4'h0;
    tick();
    REQ0_VALID = 1'b0;
    tick();
    for (int k = 1; k <= 20; k++) tick();
    @(negedge CLK);
    chk("wait_forever", {RSP_VALID, ALU_EN, RSP_ERR}, 3'b000);
    ALU_OUT = 16'h0999;
    ALU_OUT_VALID = 1'b1;
    tick();
    ALU_OUT_VALID = 1'b0;
    @(negedge CLK);
    chk("late_rsp", {RSP_VALID, RSP_ERR, RSP_ID, RSP_DATA}, {3'b100, 16'h0999});
    RSP_READY = 1'b1;
    tick();
    RSP_READY = 1'b0;
    @(negedge CLK);
`endif
    chk("final_idle", {RSP_VALID, ALU_EN}, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 16: operand/result width, signed two's complement.
REQ-002 Parameter FUN_W, default 4: ALU function code width; code bits [FUN_W-1:FUN_W-2] select the unit (00 arith, 01 logic, 10 compare, 11 shift).
REQ-003 CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 RST  in  1  asynchronous, active-low reset.
REQ-005 REQn_VALID  in  1  requester n (n=0,1) has an operation pending.
REQ-006 REQn_READY  out  1  arbiter accepts requester n's operation this cycle.
REQ-007 REQn_A, REQn_B  in  WIDTH  operands from requester n.
REQ-008 REQn_FUN  in  FUN_W  function code from requester n.
REQ-009 ALU_A, ALU_B  out  WIDTH  registered operands to the ALU.
REQ-010 ALU_FUN  out  FUN_W  registered function code to the ALU.
REQ-011 ALU_EN  out  1  single-cycle operation strobe to the ALU.
REQ-012 ALU_OUT  in  WIDTH  ALU result.
REQ-013 ALU_OUT_VALID  in  1  ALU result valid strobe.
REQ-014 RSP_VALID  out  1  response available.
REQ-015 RSP_READY  in  1  response consumer accepts.
REQ-016 RSP_ID  out  1  index of the requester the response belongs to.
REQ-017 RSP_DATA  out  WIDTH  captured ALU result.
REQ-018 RSP_ERR  out  1  response is a timeout error.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; one transaction in flight at a time.
REQ-020 IDLE: REQn_READY SHALL be high only for the granted requester; all READY low in other states.
REQ-021 Transfer SHALL occur on VALID&&READY; operands/FUN registered into ALU_A/ALU_B/ALU_FUN, grant ID stored; next state ISSUE.
REQ-022 Round-robin: if both VALID, grant the requester not served last; single VALID is granted regardless of pointer.
REQ-023 Pointer SHALL update to the granted ID at handshake; after reset REQ0 has priority.
REQ-024 ISSUE: ALU_EN high exactly one cycle; next state WAIT.
REQ-025 WAIT: on ALU_OUT_VALID capture ALU_OUT into RSP_DATA, RSP_ERR=0, next RESP; ALU_OUT_VALID in any other state SHALL be ignored.
REQ-026 RESP: RSP_VALID high, RSP_ID/RSP_DATA/RSP_ERR stable until RSP_READY; on RSP_READY go IDLE.
REQ-027 Earliest latency: handshake edge T, ALU_EN during T+1, ALU_OUT_VALID at T+2, RSP_VALID at T+3.
REQ-028 RSP_READY high in RESP's first cycle SHALL complete in that cycle; new grant possible the following cycle.
REQ-029 ALU_A/ALU_B/ALU_FUN SHALL hold their values between transactions.

Reset
REQ-030 RST low SHALL asynchronously force IDLE, all outputs 0, pointer to REQ0-priority, timeout counter 0.
REQ-031 Reset mid-transaction SHALL drop it; no response produced after release.

Configuration
REQ-032 Macro ALU_ARB_TIMEOUT_EN defined: 4-bit counter cleared on entering WAIT, incremented each WAIT cycle; at 15 cycles without ALU_OUT_VALID go RESP with RSP_ERR=1, RSP_DATA=0.
REQ-033 ALU_OUT_VALID in the cycle the count reaches 15 SHALL win (normal response).
REQ-034 Macro undefined: no counter, WAIT indefinite, RSP_ERR tied 0.

Verification
REQ-035 Single: REQ0 A=16'sd5, B=-16'sd3, FUN=4'b0000, ALU returns 2 next cycle -> RSP_VALID at T+3, RSP_ID=0, RSP_DATA=2, RSP_ERR=0.
REQ-036 Contention: both VALID continuously for 4 transactions -> grant order 0,1,0,1.
REQ-037 Backpressure: RSP_READY low 5 cycles -> RSP_VALID/RSP_DATA stable, both READY low, no new ALU_EN.
REQ-038 Reset in WAIT: RST low 2 cycles -> all outputs 0, no response; next REQ1 request served normally.
REQ-039 With ALU_ARB_TIMEOUT_EN, ALU_OUT_VALID never asserted -> RSP_VALID 15 cycles after WAIT entry, RSP_ERR=1, RSP_DATA=0.
REQ-040 Stray ALU_OUT_VALID in IDLE with value 16'h1234 -> no response, state unchanged.
